// File: rtl/ctrl_demux_l2.sv
// Sequencer for the level-2 1:2 demux: round-robin lane selection with
// almost-full lane skipping, upstream stall request and per-lane word counters.
module ctrl_demux_l2 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             validEntrada,
  input  logic             almostFull0,
  input  logic             almostFull1,
  output logic             selector,
  output logic             pausa,
  output logic [CNT_W-1:0] cuenta0,
  output logic [CNT_W-1:0] cuenta1,
  output logic [1:0]       estado
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    PAUSE  = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             sel_r;
  logic             sel_nxt_s;
  logic             pausa_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;
  logic [1:0]       af_s;
  logic             routed_s;
  logic             pref_s;

  assign af_s     = {almostFull1, almostFull0};
  assign routed_s = (state_r == ACTIVE) && validEntrada;
  // After a routed word the other lane is preferred; otherwise stay put.
  assign pref_s   = routed_s ? ~sel_r : sel_r;

  // Next-state and next-lane decision.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    if (!enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = ACTIVE;
          if (!af_s[sel_r]) begin
            sel_nxt_s = sel_r;
          end else if (!af_s[~sel_r]) begin
            sel_nxt_s = ~sel_r;
          end else begin
            sel_nxt_s = sel_r;
          end
        end
        ACTIVE: begin
          if (!af_s[pref_s]) begin
            sel_nxt_s = pref_s;
          end else if (!af_s[~pref_s]) begin
            sel_nxt_s = ~pref_s;
          end else begin
            sel_nxt_s   = sel_r;
            state_nxt_s = PAUSE;
          end
        end
        PAUSE: begin
          if (!af_s[0] || !af_s[1]) begin
            state_nxt_s = ACTIVE;
            sel_nxt_s   = af_s[sel_r] ? ~sel_r : sel_r;
          end else begin
            state_nxt_s = PAUSE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, lane and stall registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      sel_r   <= 1'b0;
      pausa_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      pausa_r <= (state_nxt_s != ACTIVE);
    end
  end

  // Per-lane routed-word counters; wrap silently, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (routed_s && !sel_r) begin
      cnt0_r <= cnt0_r + CNT_W'(1);
    end else if (routed_s && sel_r) begin
      cnt1_r <= cnt1_r + CNT_W'(1);
    end else begin
      cnt0_r <= cnt0_r;
      cnt1_r <= cnt1_r;
    end
  end

  assign selector = sel_r;
  assign pausa    = pausa_r;
  assign cuenta0  = cnt0_r;
  assign cuenta1  = cnt1_r;
  assign estado   = state_r;

endmodule

// File: tb/tb_ctrl_demux_l2.sv
// Randomized self-checking bench for ctrl_demux_l2 against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_ctrl_demux_l2;

  localparam int CW  = 4;
  localparam int MOD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          validEntrada;
  logic          almostFull0;
  logic          almostFull1;
  logic          selector;
  logic          pausa;
  logic [CW-1:0] cuenta0;
  logic [CW-1:0] cuenta1;
  logic [1:0]    estado;

  ctrl_demux_l2 #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .validEntrada(validEntrada),
    .almostFull0(almostFull0), .almostFull1(almostFull1),
    .selector(selector), .pausa(pausa), .cuenta0(cuenta0), .cuenta1(cuenta1),
    .estado(estado)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=idle, 1=active, 2=pause; lane and word counts per lane.
  int m_mode = 0;
  int m_sel  = 0;
  int m_cnt[2] = '{0, 0};
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int af[2];
    int routed;
    int pref;
    af[0] = int'(almostFull0);
    af[1] = int'(almostFull1);
    if (reset) begin
      m_mode = 0; m_sel = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      started = 1'b1;
    end else begin
      routed = (m_mode == 1 && validEntrada) ? 1 : 0;
      if (routed == 1) m_cnt[m_sel] = (m_cnt[m_sel] + 1) % MOD;
      if (!enable) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
        if (af[m_sel] == 1 && af[1 - m_sel] == 0) m_sel = 1 - m_sel;
      end else if (m_mode == 1) begin
        pref = (routed == 1) ? 1 - m_sel : m_sel;
        if (af[pref] == 0) m_sel = pref;
        else if (af[1 - pref] == 0) m_sel = 1 - pref;
        else m_mode = 2;
      end else begin
        if (af[0] == 0 || af[1] == 0) begin
          m_mode = 1;
          if (af[m_sel] == 1) m_sel = 1 - m_sel;
        end
      end
    end
    #1;
    if (started) begin
      chk("model_estado", estado, m_mode);
      chk("model_pausa", pausa, (m_mode != 1) ? 1 : 0);
      chk("model_selector", selector, m_sel);
      chk("model_cuenta0", cuenta0, m_cnt[0]);
      chk("model_cuenta1", cuenta1, m_cnt[1]);
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; validEntrada = 1'b0;
    almostFull0 = 1'b0; almostFull1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_estado", estado, 0);
    chk("rst_pausa", pausa, 1);
    chk("rst_selector", selector, 0);
    chk("rst_cuenta0", cuenta0, 0);
    chk("rst_cuenta1", cuenta1, 0);

    // Enable with a word present: ignored while still idle.
    enable = 1'b1; validEntrada = 1'b1;
    @(negedge clk);
    chk("en_estado", estado, 1);
    chk("en_pausa", pausa, 0);
    chk("en_cuenta0", cuenta0, 0);

    // Round-robin over six words.
    for (int i = 0; i < 6; i++) begin
      chk("rr_selector", selector, i % 2);
      @(negedge clk);
    end
    validEntrada = 1'b0;
    chk("rr_cuenta0", cuenta0, 3);
    chk("rr_cuenta1", cuenta1, 3);

    // Gaps: selector holds across idle cycles.
    validEntrada = 1'b1; @(negedge clk);
    validEntrada = 1'b0; @(negedge clk);
    chk("gap_selector_a", selector, 1);
    @(negedge clk);
    chk("gap_selector_b", selector, 1);
    validEntrada = 1'b1; @(negedge clk);
    validEntrada = 1'b0;
    chk("gap_selector_c", selector, 0);
    chk("gap_cuenta1", cuenta1, 4);

    // Lane 1 almost-full: four words all land on lane 0.
    almostFull1 = 1'b1; validEntrada = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("skip_selector", selector, 0);
      @(negedge clk);
    end
    chk("skip_cuenta0", cuenta0, 8);
    chk("skip_cuenta1", cuenta1, 4);

    // Both almost-full with a word present: word counted, then pause.
    almostFull0 = 1'b1;
    @(negedge clk);
    chk("pause_estado", estado, 2);
    chk("pause_pausa", pausa, 1);
    chk("pause_cuenta0", cuenta0, 9);
    repeat (2) @(negedge clk);
    chk("pause_hold_cuenta0", cuenta0, 9);
    almostFull0 = 1'b0; validEntrada = 1'b0;
    @(negedge clk);
    chk("resume_estado", estado, 1);
    chk("resume_selector", selector, 0);
    almostFull1 = 1'b0;

    // Randomized phase with occasional disable and reset.
    for (int i = 0; i < 600; i++) begin
      validEntrada = 1'($urandom_range(0, 3) != 0);
      almostFull0  = 1'($urandom_range(0, 3) == 0);
      almostFull1  = 1'($urandom_range(0, 3) == 0);
      enable       = 1'($urandom_range(0, 15) != 0);
      reset        = 1'($urandom_range(0, 63) == 0);
      @(negedge clk);
    end

    // Counter wrap: 34 alternating words on a 4-bit counter.
    reset = 1'b1; enable = 1'b1; validEntrada = 1'b0;
    almostFull0 = 1'b0; almostFull1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    validEntrada = 1'b1;
    repeat (34) @(negedge clk);
    validEntrada = 1'b0;
    chk("wrap_cuenta0", cuenta0, 1);
    chk("wrap_cuenta1", cuenta1, 1);

    // Reset in the middle of a burst.
    validEntrada = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_estado", estado, 0);
    chk("midrst_selector", selector, 0);
    chk("midrst_pausa", pausa, 1);
    chk("midrst_cuenta0", cuenta0, 0);
    chk("midrst_cuenta1", cuenta1, 0);
    reset = 1'b0; validEntrada = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_demux_l2.md
# ctrl_demux_l2

Controller that sequences the level-2 1:2 demultiplexer of the 8-bit data path. It drives the demux `selector`, spreading valid input words across lanes 0 and 1 in round-robin order. Lanes whose downstream FIFO reports almost-full are skipped, and the upstream source is stalled when both lanes are almost-full. It also keeps per-lane word counters for verification and debug.

## Interface
- `CNT_W`, default 8: width of the per-lane routed-word counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  controller run request.
- `validEntrada`  in  1  a word is present on the demux input this cycle.
- `almostFull0`  in  1  lane 0 downstream FIFO almost-full.
- `almostFull1`  in  1  lane 1 downstream FIFO almost-full.
- `selector`  out  1  lane for the current input word (0 → `Salida0`, 1 → `Salida1`). Registered.
- `pausa`  out  1  stall request to the upstream source. Registered-state decode; no combinational input path.
- `cuenta0`  out  CNT_W  words routed to lane 0, modulo 2^CNT_W.
- `cuenta1`  out  CNT_W  words routed to lane 1, modulo 2^CNT_W.
- `estado`  out  2  state: IDLE=2'b00, ACTIVE=2'b01, PAUSE=2'b10. 2'b11 is unused and recovers to IDLE.

## Operation
- **Reset values:** `estado`=IDLE, `selector`=0, `pausa`=1, `cuenta0`=`cuenta1`=0.
- **Routed word:** `estado`==ACTIVE && `validEntrada`==1. The word goes to lane `selector` in that same cycle, and `cuenta[selector]` increments at the next edge.
- **Almost-full is advisory during ACTIVE.** A routed word is never dropped or redirected because of almost-full; FIFOs guarantee at least 2 words of headroom.
- **Valid words outside ACTIVE** (IDLE, PAUSE) are ignored: not routed, not counted.
- **Lane choice each cycle in ACTIVE:**
  - `pref` = ~`selector` if a word was routed this cycle, else `selector`.
  - If !af[`pref`], next `selector` = `pref`.
  - Else if !af[~`pref`], next `selector` = ~`pref`.
  - Else `selector` holds and next state = PAUSE.
- **Transitions (priority top-down):**
  - `reset` → IDLE.
  - `enable`==0 → IDLE from any state. A word routed in that cycle is still counted; `selector` holds.
  - IDLE & `enable` → ACTIVE. `selector` uses the lane-choice rule with routed=0.
  - ACTIVE & both af → PAUSE.
  - PAUSE & (!`almostFull0` | !`almostFull1`) → ACTIVE. Next `selector` = `selector` if !af[`selector`], else ~`selector`.
  - Otherwise hold state.
- **Outputs and counters:**
  - `pausa` = (`estado` != ACTIVE).
  - Counters wrap from 2^CNT_W−1 to 0 with no flag.
  - Counters clear only on `reset`; IDLE does not clear them.

## Timing
- Zero-latency routing: `selector` is valid in the same cycle as the word it steers.
- `selector` update latency: 1 cycle from a routed word or an almost-full change.
- Almost-full rising at edge N (sampled during cycle N) steers `selector` from edge N+1.
- Both almost-full sampled in cycle N → `pausa`=1 from edge N+1. A word presented in cycle N is still routed; upstream must tolerate this.
- Almost-full release sampled in cycle N → `pausa`=0 and ACTIVE from edge N+1.
- `enable` low in cycle N → IDLE and `pausa`=1 from edge N+1.
- `enable` high in IDLE → ACTIVE after 1 cycle. No word is routed in the cycle `enable` first rises.
- `reset` high in any cycle, mid-burst included → all outputs at reset values after that edge. The word presented in the reset cycle is not counted.
- Simultaneous routed word and same-lane almost-full: the word goes to the current lane; only the next choice is affected.

## Test plan
- **Reset/enable:** `reset` 2 cycles, then `enable`=1 → `estado` IDLE→ACTIVE one edge after `enable`; `pausa` 1→0; `selector`=0; counters 0.
- **Round-robin:** ACTIVE, no af, `validEntrada`=1 for 6 cycles → `selector` 0,1,0,1,0,1; `cuenta0`=`cuenta1`=3. With `validEntrada` gaps, `selector` holds across the idle cycles.
- **Skip lane:** `almostFull1`=1 held, 4 valid words → all go to lane 0, `selector` stays 0; `cuenta0`=4, `cuenta1` unchanged.
- **Pause/resume:** both af at cycle N with a word present → word counted; `pausa`=1 and `estado`=PAUSE at N+1; valid words during PAUSE are not counted. Drop `almostFull0` → ACTIVE next edge with `selector`=0.
- **Counter wrap with CNT_W=4:** 34 words alternating lanes → `cuenta0`=`cuenta1`=1 (17 mod 16).
- **Reset mid-burst:** `reset` asserted during streaming after 5 words → next edge `estado`=IDLE, `selector`=0, `pausa`=1, counters 0.
